rescale_stream: RTL



---
 rtl/rescale_stream.sv | 110 +++++++++++
 1 files changed

// File: rtl/rescale_stream.sv
`default_nettype none
// ============================================================================
// rescale_stream : multi-lane shift/round/saturate rescaler, valid/ready stream
// Revision 1.0
// ============================================================================
module rescale_stream #(
  parameter int NUM_WIDTH = 33,
  parameter int IMG_WIDTH = 16,
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    shift,
  input  logic                          round_en,
  input  logic [CHANNELS*NUM_WIDTH-1:0] up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  output logic [CHANNELS*IMG_WIDTH-1:0] dn_data,
  output logic [CHANNELS-1:0]           dn_sat,
  output logic                          dn_valid,
  input  logic                          dn_ready,
  input  logic                          sat_clr,
  output logic [CNT_WIDTH-1:0]          sat_count
);

  localparam int W2 = NUM_WIDTH + 1;
  localparam logic [7:0] c_shift_max = 8'(NUM_WIDTH);
  localparam logic signed [W2-1:0] c_img_max = {{(W2-IMG_WIDTH+1){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
  localparam logic signed [W2-1:0] c_img_min = {{(W2-IMG_WIDTH+1){1'b1}}, {(IMG_WIDTH-1){1'b0}}};

  logic                          en;
  logic [7:0]                    shift_clamped;
  logic                          s1_valid_q;
  logic [CHANNELS*NUM_WIDTH-1:0] s1_data_q;
  logic [7:0]                    s1_shift_q;
  logic                          s1_round_q;
  logic                          s2_valid_q;
  logic [CHANNELS*W2-1:0]        s2_val_q;
  logic [CHANNELS*W2-1:0]        s2_val_d;
  logic [CHANNELS*IMG_WIDTH-1:0] dn_data_d;
  logic [CHANNELS-1:0]           dn_sat_d;
  logic                          sat_inc;

  assign en            = ~dn_valid | dn_ready;
  assign up_ready      = en;
  assign shift_clamped = (shift >= c_shift_max) ? c_shift_max : shift;

  // Lane math is done in NUM_WIDTH+1 bits so the rounding bias can never overflow.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic signed [W2-1:0] x_ext;
    logic signed [W2-1:0] bias;
    logic signed [W2-1:0] sum;
    logic signed [W2-1:0] res;
    logic signed [W2-1:0] v;

    assign x_ext = W2'($signed(s1_data_q[k*NUM_WIDTH +: NUM_WIDTH]));
    assign bias  = (s1_round_q && (s1_shift_q != 8'd0)) ?
                   (W2'(1) << (s1_shift_q - 8'd1)) : '0;
    assign sum   = x_ext + bias;
    assign res   = sum >>> s1_shift_q;
    assign s2_val_d[k*W2 +: W2] = res;

    assign v = $signed(s2_val_q[k*W2 +: W2]);
    assign dn_sat_d[k] = (v > c_img_max) || (v < c_img_min);
    assign dn_data_d[k*IMG_WIDTH +: IMG_WIDTH] =
      (v > c_img_max) ? c_img_max[IMG_WIDTH-1:0] :
      (v < c_img_min) ? c_img_min[IMG_WIDTH-1:0] : v[IMG_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_shift_q <= '0;
      s1_round_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_val_q   <= '0;
      dn_valid   <= 1'b0;
      dn_data    <= '0;
      dn_sat     <= '0;
    end else if (en) begin
      s1_valid_q <= up_valid;
      if (up_valid) begin
        s1_data_q  <= up_data;
        s1_shift_q <= shift_clamped;
        s1_round_q <= round_en;
      end
      s2_valid_q <= s1_valid_q;
      s2_val_q   <= s2_val_d;
      dn_valid   <= s2_valid_q;
      dn_data    <= dn_data_d;
      dn_sat     <= dn_sat_d;
    end
  end

  assign sat_inc = dn_valid & dn_ready & (|dn_sat) & (sat_count != {CNT_WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (sat_inc) begin
      sat_count <= sat_count + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire
